// File: rtl/rx_commit_uart_tx.sv
// Commit-gated payload buffer feeding an 8N1 UART transmitter with a 16x-baud tick generator.
// Build option: define RX_COMMIT_PARITY_EN to insert an even-parity bit between data and stop.
module rx_commit_uart_tx #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned BAUD_DIV = 55
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_pyld_data,
    input  logic              i_pyld_valid,
    output logic              o_pyld_ready,
    input  logic              i_crc_err,
    input  logic              i_crc_err_valid,
    output logic              o_uart_tx,
    output logic              o_busy,
    output logic [7:0]        o_drop_cnt,
    output logic              o_overflow
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned BDW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BDW-1:0] BaudLast = BDW'(BAUD_DIV - 1);
    localparam logic [BIW-1:0] BitLast  = BIW'(DATA_W - 1);
    localparam logic [PW-1:0]  DepthVal = PW'(DEPTH);

`ifdef RX_COMMIT_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] buf_mem [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     cmt_ptr_q, cmt_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              discard_q, discard_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q, drop_d;

    logic [BDW-1:0]    baud_cnt_q, baud_cnt_d;

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        sub_q, sub_d;
    logic [BIW-1:0]    bit_q, bit_d;
    logic              tx_q, tx_d;
`ifdef RX_COMMIT_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [PW-1:0]     used;
    logic              full;
    logic              ovf_trig;
    logic              discard_now;
    logic              wr_en;
    logic              tick;
    logic              bit_end;

    // ------------------------------------------------------------------
    // Baud tick
    // ------------------------------------------------------------------
    always_comb begin
        tick       = (baud_cnt_q == BaudLast);
        baud_cnt_d = tick ? '0 : baud_cnt_q + BDW'(1);
    end

    // ------------------------------------------------------------------
    // Buffer pointers, commit / rollback, overflow
    // ------------------------------------------------------------------
    always_comb begin
        used        = wr_ptr_q - rd_ptr_q;
        full        = (used == DepthVal);
        // An all-uncommitted full buffer can never drain, so the frame must be dropped.
        ovf_trig    = full && (cmt_ptr_q == rd_ptr_q) && !discard_q;
        discard_now = discard_q | ovf_trig;

        o_pyld_ready = !full | discard_now;
        wr_en        = i_pyld_valid & o_pyld_ready & !discard_now;

        wr_ptr_d   = wr_ptr_q + PW'(wr_en);
        cmt_ptr_d  = cmt_ptr_q;
        discard_d  = discard_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (ovf_trig) begin
            overflow_d = 1'b1;
            discard_d  = 1'b1;
            wr_ptr_d   = cmt_ptr_q;
        end

        if (i_crc_err_valid) begin
            if (discard_now) begin
                discard_d = 1'b0;
                drop_d    = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
            end else if (i_crc_err) begin
                wr_ptr_d = cmt_ptr_q;
                drop_d   = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
            end else begin
                cmt_ptr_d = wr_ptr_d;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            buf_mem[wr_ptr_q[AW-1:0]] <= i_pyld_data;
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    assign bit_end = tick && (sub_q == 4'hF);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        sub_d    = sub_q;
        bit_d    = bit_q;
        rd_ptr_d = rd_ptr_q;
        tx_d     = 1'b1;
`ifdef RX_COMMIT_PARITY_EN
        par_d    = par_q;
`endif

        if (state_q != StIdle && tick) begin
            sub_d = sub_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (rd_ptr_q != cmt_ptr_q) begin
                    shift_d  = buf_mem[rd_ptr_q[AW-1:0]];
`ifdef RX_COMMIT_PARITY_EN
                    par_d    = ^buf_mem[rd_ptr_q[AW-1:0]];
`endif
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    sub_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == BitLast) begin
`ifdef RX_COMMIT_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d   = bit_q + BIW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef RX_COMMIT_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef RX_COMMIT_PARITY_EN
            StParity: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            discard_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            baud_cnt_q <= '0;
            state_q    <= StIdle;
            shift_q    <= '0;
            sub_q      <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
`ifdef RX_COMMIT_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            discard_q  <= discard_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            baud_cnt_q <= baud_cnt_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
`ifdef RX_COMMIT_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign o_uart_tx  = tx_q;
    assign o_busy     = (state_q != StIdle) || (rd_ptr_q != cmt_ptr_q);
    assign o_drop_cnt = drop_q;
    assign o_overflow = overflow_q;

    // ------------------------------------------------------------------
    // Pointer ordering invariants: rd <= cmt <= wr, occupancy <= DEPTH
    // ------------------------------------------------------------------
    a_occupancy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (wr_ptr_q - rd_ptr_q) <= DepthVal);
    a_cmt_order: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (PW'(cmt_ptr_q - rd_ptr_q)) <= (PW'(wr_ptr_q - rd_ptr_q)));

endmodule

// File: tb/tb_rx_commit_uart_tx.sv
// Directed bench for rx_commit_uart_tx: a frame-level commit/rollback model plus a line decoder.
// Honours RX_COMMIT_PARITY_EN the same way the design does.
module tb_rx_commit_uart_tx;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned BAUD_DIV = 4;
    localparam int          BIT_CLK  = 16 * BAUD_DIV;
    localparam int          HALF     = BIT_CLK / 2;
`ifdef RX_COMMIT_PARITY_EN
    localparam int          STOP_K   = DATA_W + 2;
`else
    localparam int          STOP_K   = DATA_W + 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] pyld_data = '0;
    logic              pyld_valid = 1'b0;
    logic              pyld_ready;
    logic              crc_err = 1'b0;
    logic              crc_err_valid = 1'b0;
    logic              uart_tx;
    logic              busy;
    logic [7:0]        drop_cnt;
    logic              overflow;

    always #5 clk = ~clk;

    rx_commit_uart_tx #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_pyld_data     (pyld_data),
        .i_pyld_valid    (pyld_valid),
        .o_pyld_ready    (pyld_ready),
        .i_crc_err       (crc_err),
        .i_crc_err_valid (crc_err_valid),
        .o_uart_tx       (uart_tx),
        .o_busy          (busy),
        .o_drop_cnt      (drop_cnt),
        .o_overflow      (overflow)
    );

    int n_chk = 0;
    int n_err = 0;

    // Frame-level model: bytes of the open frame wait in pend_q until the verdict.
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] pend_q [$];
    logic [DATA_W-1:0] rx_log [$];
    int                rx_slen [$];
    bit                mdl_disc = 1'b0;
    bit                mdl_ovf = 1'b0;
    int                mdl_drop = 0;

    // Line decoder state
    bit                rx_act = 1'b0;
    int                rx_cnt = 0;
    int                rx_first = 0;
    bit                rx_rise = 1'b0;
    bit                prev_tx = 1'b1;
    logic [DATA_W-1:0] rx_data = '0;
`ifdef RX_COMMIT_PARITY_EN
    logic              rx_par = 1'b0;
`endif
    int                cyc = 0;
    int                last_stop_cyc = 0;
    int                stall_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic void mdl_bump();
        if (mdl_drop < 255) mdl_drop++;
    endfunction

    function automatic void mdl_byte(input logic [DATA_W-1:0] d);
        if (mdl_disc) return;
        pend_q.push_back(d);
        // Only exercised with the transmitter fully drained, so "all uncommitted" == "pend full".
        if (pend_q.size() == int'(DEPTH) && exp_q.size() == 0) begin
            mdl_ovf  = 1'b1;
            mdl_disc = 1'b1;
            pend_q.delete();
        end
    endfunction

    function automatic void mdl_verdict(input bit err);
        if (mdl_disc) begin
            mdl_disc = 1'b0;
            mdl_bump();
        end else if (err) begin
            pend_q.delete();
            mdl_bump();
        end else begin
            foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
            pend_q.delete();
        end
    endfunction

    function automatic void mdl_reset();
        exp_q.delete();
        pend_q.delete();
        mdl_disc = 1'b0;
        mdl_ovf  = 1'b0;
        mdl_drop = 0;
    endfunction

    task automatic send(input logic [DATA_W-1:0] d, input bit with_verdict, input bit err);
        int st;
        @(negedge clk);
        pyld_data     = d;
        pyld_valid    = 1'b1;
        crc_err_valid = with_verdict;
        crc_err       = err;
        st = 0;
        while (!pyld_ready && st < 3000) begin
            @(negedge clk);
            st++;
        end
        stall_total += st;
        if (st >= 3000) begin
            check("write_accept_ready", pyld_ready, 1);
        end else begin
            @(posedge clk);
            mdl_byte(d);
            if (with_verdict) mdl_verdict(err);
        end
        #1;
        pyld_valid    = 1'b0;
        crc_err_valid = 1'b0;
        crc_err       = 1'b0;
    endtask

    task automatic verdict(input bit err);
        @(negedge clk);
        crc_err_valid = 1'b1;
        crc_err       = err;
        @(posedge clk);
        mdl_verdict(err);
        #1;
        crc_err_valid = 1'b0;
        crc_err       = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((busy || rx_act) && n < 4000);
        check({name, "_busy_low"}, busy, 0);
        check({name, "_all_chars_seen"}, exp_q.size(), 0);
    endtask

    // Per-cycle compare: drop counter against the model, and a UART decoder on the line.
    initial begin : monitor
        int k;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rx_act  = 1'b0;
                prev_tx = 1'b1;
            end else begin
                check("drop_cnt_vs_model", drop_cnt, mdl_drop);
                if (!rx_act) begin
                    if (prev_tx && !uart_tx) begin
                        rx_act   = 1'b1;
                        rx_cnt   = 0;
                        rx_rise  = 1'b0;
                        rx_first = 0;
                        rx_data  = '0;
                    end
                end else begin
                    rx_cnt++;
                    if (!rx_rise && uart_tx) begin
                        rx_rise  = 1'b1;
                        rx_first = rx_cnt;
                    end
                    if (rx_cnt >= HALF && ((rx_cnt - HALF) % BIT_CLK) == 0) begin
                        k = (rx_cnt - HALF) / BIT_CLK;
                        if (k == 0) begin
                            check("start_bit", uart_tx, 0);
                        end else if (k <= int'(DATA_W)) begin
                            rx_data[k-1] = uart_tx;
`ifdef RX_COMMIT_PARITY_EN
                        end else if (k == int'(DATA_W) + 1) begin
                            rx_par = uart_tx;
                            check("parity_bit", rx_par, ^rx_data);
`endif
                        end else if (k == STOP_K) begin
                            check("stop_bit", uart_tx, 1);
                            last_stop_cyc = cyc;
                            rx_log.push_back(rx_data);
                            rx_slen.push_back(rx_first);
                            if (exp_q.size() == 0) begin
                                n_chk++;
                                n_err++;
                                $display("FAIL unexpected_char: got 0x%0h expected none", rx_data);
                            end else begin
                                check("rx_char_vs_model", rx_data, exp_q[0]);
                                void'(exp_q.pop_front());
                            end
                            rx_act = 1'b0;
                        end
                    end
                end
                prev_tx = uart_tx;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_drop_cnt", drop_cnt, 0);
        check("reset_overflow", overflow, 0);
        check("reset_ready", pyld_ready, 1);
        rst_n = 1'b1;

        // Three committed bytes go out back to back.
        send(8'h41, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        send(8'h43, 1'b1, 1'b0);
        check("busy_after_commit", busy, 1);
        wait_idle("t1");
        check_rng("t1_busy_fall_after_stop_mid", cyc - last_stop_cyc, 24, 38);
        check("t1_char_count", rx_log.size(), 3);
        if (rx_log.size() >= 3) begin
            check("t1_char0", rx_log[0], 8'h41);
            check("t1_char1", rx_log[1], 8'h42);
            check("t1_char2", rx_log[2], 8'h43);
            check_rng("t1_start_bit_len", rx_slen[0], BIT_CLK - BAUD_DIV + 1, BIT_CLK);
        end
        check("t1_overflow", overflow, 0);

        // Bad frame rolled back, following good frame delivered.
        for (int i = 1; i <= 5; i++) send(DATA_W'(i), 1'b0, 1'b0);
        verdict(1'b1);
        send(8'h55, 1'b0, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        wait_idle("t2");
        check("t2_char_count", rx_log.size(), 5);
        if (rx_log.size() >= 5) begin
            check("t2_char3", rx_log[3], 8'h55);
            check("t2_char4", rx_log[4], 8'hAA);
        end
        check("t2_drop_cnt", drop_cnt, 1);

        // Rollback of frame B while committed frame A is on the wire.
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), (i == 3), 1'b0);
        n = 0;
        while (!rx_act && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t3_a_started", rx_act, 1);
        for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 1'b0, 1'b0);
        verdict(1'b1);
        wait_idle("t3");
        check("t3_char_count", rx_log.size(), 9);
        if (rx_log.size() >= 9) begin
            for (int i = 0; i < 4; i++) check("t3_frame_a", rx_log[5+i], 8'hA0 + 8'(i));
        end
        check("t3_drop_cnt", drop_cnt, 2);

        // Overflow: a frame larger than the buffer.
        stall_total = 0;
        for (int i = 0; i < int'(DEPTH); i++) send(8'hC0 + 8'(i), 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t4_overflow_set", overflow, 1);
        check("t4_overflow_vs_model", overflow, mdl_ovf);
        check("t4_ready_in_overflow", pyld_ready, 1);
        for (int i = 0; i < 3; i++) send(8'hD0 + 8'(i), 1'b0, 1'b0);
        check("t4_no_stalls", stall_total, 0);
        verdict(1'b0);
        wait_idle("t4");
        repeat (300) @(negedge clk);
        check("t4_nothing_sent", rx_log.size(), 9);
        check("t4_drop_cnt", drop_cnt, 3);

        // Last byte coincident with the verdict.
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b1, 1'b1);
        wait_idle("t5");
        check("t5_char_count", rx_log.size(), 11);
        if (rx_log.size() >= 11) begin
            check("t5_char9", rx_log[9], 8'h11);
            check("t5_char10", rx_log[10], 8'h22);
        end
        check("t5_drop_cnt", drop_cnt, 4);

        // Asynchronous reset in the middle of a low data bit.
        send(8'hF0, 1'b0, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        n = 0;
        while (!(rx_act && rx_cnt >= HALF + 3 * BIT_CLK) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("t6_line_low_before_reset", uart_tx, 0);
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check("t6_reset_uart_tx", uart_tx, 1);
        check("t6_reset_drop_cnt", drop_cnt, 0);
        check("t6_reset_busy", busy, 0);
        check("t6_reset_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h07, 1'b1, 1'b0);
        wait_idle("t6");
        check("t6_char_count", rx_log.size(), 12);
        if (rx_log.size() >= 12) check("t6_char", rx_log[11], 8'h07);
`ifdef RX_COMMIT_PARITY_EN
        check("t6_parity_0x07", rx_par, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
